// File: rtl/img_pkg.sv
// Shared constants and frame-state type for the 3x3 window generator.
package img_pkg;

    localparam int unsigned PIX_DW    = 8;
    localparam int unsigned DEF_IMG_W = 640;
    localparam int unsigned DEF_IMG_H = 480;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } frame_state_e;

endpackage : img_pkg

// File: rtl/img_line_buf.sv
// Beat-enabled delay line of DEPTH beats. Circular RAM whose read tap is the slot
// about to be overwritten, so dout equals the din from DEPTH accepted beats ago.
module img_line_buf
    import img_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_IMG_W,
    parameter int unsigned DW    = PIX_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is deliberately not reset; stale content is masked by the row gating upstream.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[ptr_q] <= din;
        end
    end

    assign dout = mem_q[ptr_q];

endmodule : img_line_buf

// File: rtl/img_matrix_gen_3_3.sv
// Raster pixel stream to sliding 3x3 window generator feeding the median filter.
// Only fully interior windows are emitted, one matrix_en strobe per window.
module img_matrix_gen_3_3
    import img_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned DW    = PIX_DW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_vsync,
    input  logic                      pix_de,
    input  logic [DW-1:0]             pix_data,
    output logic [DW-1:0]             matrix_p11,
    output logic [DW-1:0]             matrix_p12,
    output logic [DW-1:0]             matrix_p13,
    output logic [DW-1:0]             matrix_p21,
    output logic [DW-1:0]             matrix_p22,
    output logic [DW-1:0]             matrix_p23,
    output logic [DW-1:0]             matrix_p31,
    output logic [DW-1:0]             matrix_p32,
    output logic [DW-1:0]             matrix_p33,
    output logic                      matrix_en,
    output logic [$clog2(IMG_W)-1:0]  matrix_x,
    output logic [$clog2(IMG_H)-1:0]  matrix_y,
    output logic                      frame_done
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    frame_state_e  state_q, state_d;
    logic          vs_q;
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    logic [DW-1:0] win_q [3][3];
    logic [DW-1:0] win_d [3][3];
    logic          en_q, en_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          done_q, done_d;

    logic          vs_rise_c;
    logic          accept_c;
    logic [DW-1:0] lb1_out;
    logic [DW-1:0] lb2_out;

    assign vs_rise_c = pix_vsync & ~vs_q;
    assign accept_c  = (state_q == ACTIVE) & pix_de & ~vs_rise_c;

    img_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (accept_c),
        .din  (pix_data),
        .dout (lb1_out)
    );

    img_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb2 (
        .clk  (clk),
        .rst  (rst),
        .en   (accept_c),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    // Frame FSM, raster counters and window shift; vsync rise overrides everything.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        en_d    = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;

        if (vs_rise_c) begin
            state_d = ACTIVE;
            col_d   = '0;
            row_d   = '0;
        end else if (accept_c) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb2_out;
            win_d[1][2] = lb1_out;
            win_d[2][2] = pix_data;

            if ((row_q >= YW'(2)) && (col_q >= XW'(2))) begin
                en_d = 1'b1;
                x_d  = col_q - XW'(1);
                y_d  = row_q - YW'(1);
            end

            if (col_q == XW'(IMG_W - 1)) begin
                col_d = '0;
                if (row_q == YW'(IMG_H - 1)) begin
                    row_d   = '0;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    row_d = row_q + YW'(1);
                end
            end else begin
                col_d = col_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vs_q    <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '{default: '0};
            en_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= pix_vsync;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            en_q    <= en_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign matrix_p11 = win_q[0][0];
    assign matrix_p12 = win_q[0][1];
    assign matrix_p13 = win_q[0][2];
    assign matrix_p21 = win_q[1][0];
    assign matrix_p22 = win_q[1][1];
    assign matrix_p23 = win_q[1][2];
    assign matrix_p31 = win_q[2][0];
    assign matrix_p32 = win_q[2][1];
    assign matrix_p33 = win_q[2][2];
    assign matrix_en  = en_q;
    assign matrix_x   = x_q;
    assign matrix_y   = y_q;
    assign frame_done = done_q;

endmodule : img_matrix_gen_3_3

// File: tb/tb_img_matrix_gen_3_3.sv
// Self-checking bench for img_matrix_gen_3_3 on an 8x6 frame with pixel = 16*row+col.
module tb_img_matrix_gen_3_3;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_vsync;
    logic       pix_de;
    logic [7:0] pix_data;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic       matrix_en;
    logic [2:0] matrix_x;
    logic [2:0] matrix_y;
    logic       frame_done;

    img_matrix_gen_3_3 #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_vsync  (pix_vsync),
        .pix_de     (pix_de),
        .pix_data   (pix_data),
        .matrix_p11 (p11),
        .matrix_p12 (p12),
        .matrix_p13 (p13),
        .matrix_p21 (p21),
        .matrix_p22 (p22),
        .matrix_p23 (p23),
        .matrix_p31 (p31),
        .matrix_p32 (p32),
        .matrix_p33 (p33),
        .matrix_en  (matrix_en),
        .matrix_x   (matrix_x),
        .matrix_y   (matrix_y),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  x;
        logic [2:0]  y;
        logic [71:0] p;
        logic        done;
    } win_t;

    typedef struct {
        int gap_pct;
        int hblank;
        int extra_beats;
        int exp_windows;
    } scen_t;

    win_t  exp_q[$];
    scen_t tbl[3];
    int    errors   = 0;
    int    checks   = 0;
    int    win_cnt  = 0;
    int    done_cnt = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic win_t model(input int r, input int c);
        win_t w;
        w.x    = 3'(c - 1);
        w.y    = 3'(r - 1);
        w.done = (r == H - 1) && (c == W - 1);
        w.p    = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                w.p[(8 - (dr * 3 + dc)) * 8 +: 8] = 8'(16 * (r - 2 + dr) + (c - 2 + dc));
            end
        end
        return w;
    endfunction

    function automatic logic [79:0] all_outs();
        return {p11, p12, p13, p21, p22, p23, p31, p32, p33, matrix_en, matrix_x, matrix_y, frame_done};
    endfunction

    // Output monitor: every window strobe is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (matrix_en) begin
                win_t act;
                win_cnt++;
                if (frame_done) done_cnt++;
                act = '{x: matrix_x, y: matrix_y,
                        p: {p11, p12, p13, p21, p22, p23, p31, p32, p33}, done: frame_done};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window: got x=%0d y=%0d expected no window", matrix_x, matrix_y);
                end else begin
                    check("window", 80'(act), 80'(exp_q.pop_front()));
                end
            end else if (frame_done) begin
                checks++;
                errors++;
                $display("FAIL done_without_en: got frame_done=1 matrix_en=0 expected both or neither");
            end
        end
    end

    task automatic step(input logic vs, input logic de, input logic [7:0] d);
        @(posedge clk);
        #1;
        pix_vsync = vs;
        pix_de    = de;
        pix_data  = d;
    endtask

    // Vsync rise with a coincident junk beat (must be dropped), then up to `limit` beats.
    task automatic send_frame(input int gap_pct, input int hblank, input int limit);
        int n = 0;
        step(1'b1, 1'b1, 8'hEE);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (n < limit) begin
                    while ($urandom_range(0, 99) < gap_pct) step(1'b0, 1'b0, 8'($urandom));
                    step(1'b0, 1'b1, 8'(16 * r + c));
                    if (r >= 2 && c >= 2) exp_q.push_back(model(r, c));
                    n++;
                end
            end
            if (n < limit) repeat (hblank) step(1'b0, 1'b0, 8'($urandom));
        end
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_end_checks(input string tag, input int exp_win);
        repeat (4) step(1'b0, 1'b0, 8'h00);
        check({tag, "_win_count"}, 80'(win_cnt), 80'(exp_win));
        check({tag, "_done_count"}, 80'(done_cnt), 80'd1);
        check({tag, "_queue_empty"}, 80'(exp_q.size()), 80'd0);
        check({tag, "_last_p33"}, 80'(p33), 80'h57);
        check({tag, "_last_xy"}, 80'({matrix_x, matrix_y}), 80'({3'd6, 3'd4}));
    endtask

    initial begin
        tbl[0] = '{gap_pct: 0,  hblank: 0, extra_beats: 0,  exp_windows: 24};
        tbl[1] = '{gap_pct: 30, hblank: 4, extra_beats: 0,  exp_windows: 24};
        tbl[2] = '{gap_pct: 0,  hblank: 4, extra_beats: 10, exp_windows: 24};

        rst       = 1'b1;
        pix_vsync = 1'b0;
        pix_de    = 1'b0;
        pix_data  = 8'h00;

        // Reset held with pixel beats toggling.
        repeat (6) @(negedge clk) begin
            check("reset_outputs", all_outs(), 80'd0);
            pix_de   = ~pix_de;
            pix_data = 8'($urandom);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Beats before any vsync are ignored.
        repeat (5) step(1'b0, 1'b1, 8'($urandom));
        repeat (2) step(1'b0, 1'b0, 8'h00);
        check("idle_no_output", all_outs(), 80'd0);

        foreach (tbl[i]) begin
            win_cnt  = 0;
            done_cnt = 0;
            send_frame(tbl[i].gap_pct, tbl[i].hblank, W * H);
            repeat (tbl[i].extra_beats) step(1'b0, 1'b1, 8'($urandom));
            frame_end_checks($sformatf("scen%0d", i), tbl[i].exp_windows);
        end

        // Reset during row 3, then beats without vsync, then a clean frame.
        win_cnt  = 0;
        done_cnt = 0;
        send_frame(0, 0, 3 * W + 4);
        repeat (2) step(1'b0, 1'b0, 8'h00);
        check("pre_reset_windows", 80'(win_cnt), 80'd8);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk) begin
            check("midframe_reset_outputs", all_outs(), 80'd0);
            pix_de   = ~pix_de;
            pix_data = 8'($urandom);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) step(1'b0, 1'b1, 8'($urandom));
        repeat (2) step(1'b0, 1'b0, 8'h00);
        check("post_reset_ignored", all_outs(), 80'd0);
        win_cnt = 0;
        send_frame(0, 0, W * H);
        frame_end_checks("after_reset", 24);

        // Vsync rise in the middle of row 4 restarts the frame.
        win_cnt  = 0;
        done_cnt = 0;
        send_frame(0, 2, 4 * W + 5);
        send_frame(0, 0, W * H);
        frame_end_checks("vsync_restart", 15 + 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_img_matrix_gen_3_3
